// File: rtl/countdown_pressurize.sv
// Airlock re-pressurization countdown: a sealed-door rising edge on countdown
// runs a FILL_CYCLES fill, ending in a one-cycle pressurized pulse or a latched fault.
module countdown_pressurize #(
  parameter int FILL_CYCLES = 8,
  parameter int COUNT_W     = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               countdown,
  input  logic               doors_sealed,
  output logic               pressurizing,
  output logic               pressurized,
  output logic               fault,
  output logic [COUNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_FULL = COUNT_W'(FILL_CYCLES);
  localparam logic [COUNT_W-1:0] CNT_LAST = COUNT_W'(FILL_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] cnt_nxt;
  logic               countdown_q;
  logic               start;

  // countdown_q resets high so a request held through reset is not an edge
  assign start = countdown & ~countdown_q;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= IDLE;
      cnt         <= CNT_FULL;
      countdown_q <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      countdown_q <= countdown;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (start && doors_sealed) begin
          state_nxt = FILL;
          cnt_nxt   = CNT_LAST;
        end else if (start) begin
          state_nxt = FAULT;
          cnt_nxt   = CNT_FULL;
        end
      end
      FILL: begin
        // seal loss outranks completion, even on the last fill cycle
        if (!doors_sealed) begin
          state_nxt = FAULT;
          cnt_nxt   = CNT_FULL;
        end else if (cnt == '0) begin
          state_nxt = DONE;
          cnt_nxt   = CNT_FULL;
        end else begin
          cnt_nxt = cnt - COUNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = CNT_FULL;
      end
      FAULT: begin
        if (!countdown && doors_sealed) begin
          state_nxt = IDLE;
          cnt_nxt   = CNT_FULL;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = CNT_FULL;
      end
    endcase
  end

  assign pressurizing = (state == FILL);
  assign pressurized  = (state == DONE);
  assign fault        = (state == FAULT);
  assign remaining    = cnt;

endmodule

// File: tb/tb_countdown_pressurize.sv
// Bench for countdown_pressurize: three instances (N=8, 1, 15) share stimulus and
// are compared every cycle against a phase-level model of the fill sequence.
module tb_countdown_pressurize;

  logic Clock = 1'b0;
  logic Reset;
  logic countdown;
  logic doors_sealed;

  logic       pz0, pz1, pz2;
  logic       pd0, pd1, pd2;
  logic       ft0, ft1, ft2;
  logic [3:0] rem0, rem1, rem2;

  int n_checks = 0;
  int n_fail   = 0;

  // model: fill_left = -1 when not filling, else fill cycles still shown
  int m_fill [3];
  bit m_done [3];
  bit m_fault[3];
  bit m_prev [3];
  int nval   [3] = '{8, 1, 15};
  int pz_cnt [3];
  int pd_cnt [3];

  always #5 Clock = ~Clock;

  countdown_pressurize #(.FILL_CYCLES(8), .COUNT_W(4)) u_n8 (
    .Clock(Clock), .Reset(Reset), .countdown(countdown), .doors_sealed(doors_sealed),
    .pressurizing(pz0), .pressurized(pd0), .fault(ft0), .remaining(rem0));
  countdown_pressurize #(.FILL_CYCLES(1), .COUNT_W(4)) u_n1 (
    .Clock(Clock), .Reset(Reset), .countdown(countdown), .doors_sealed(doors_sealed),
    .pressurizing(pz1), .pressurized(pd1), .fault(ft1), .remaining(rem1));
  countdown_pressurize #(.FILL_CYCLES(15), .COUNT_W(4)) u_n15 (
    .Clock(Clock), .Reset(Reset), .countdown(countdown), .doors_sealed(doors_sealed),
    .pressurizing(pz2), .pressurized(pd2), .fault(ft2), .remaining(rem2));

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic c, input logic s);
    for (int i = 0; i < 3; i++) begin
      if (!r) begin
        m_fill[i] = -1; m_done[i] = 0; m_fault[i] = 0; m_prev[i] = 1;
      end else begin
        bit rise;
        rise = c && !m_prev[i];
        m_prev[i] = c;
        if (m_done[i]) m_done[i] = 0;
        else if (m_fault[i]) begin
          if (!c && s) m_fault[i] = 0;
        end else if (m_fill[i] >= 0) begin
          if (!s) begin m_fill[i] = -1; m_fault[i] = 1; end
          else if (m_fill[i] == 0) begin m_fill[i] = -1; m_done[i] = 1; end
          else m_fill[i] = m_fill[i] - 1;
        end else if (rise) begin
          if (s) m_fill[i] = nval[i] - 1;
          else m_fault[i] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic       p, d, f;
    logic [3:0] rm;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin p = pz0; d = pd0; f = ft0; rm = rem0; end
        1: begin p = pz1; d = pd1; f = ft1; rm = rem1; end
        default: begin p = pz2; d = pd2; f = ft2; rm = rem2; end
      endcase
      chk($sformatf("pressurizing[N=%0d]", nval[i]), int'(p), int'(m_fill[i] >= 0));
      chk($sformatf("pressurized[N=%0d]", nval[i]), int'(d), int'(m_done[i]));
      chk($sformatf("fault[N=%0d]", nval[i]), int'(f), int'(m_fault[i]));
      chk($sformatf("remaining[N=%0d]", nval[i]), int'(rm),
          (m_fill[i] >= 0) ? m_fill[i] : nval[i]);
      if (p === 1'b1) pz_cnt[i]++;
      if (d === 1'b1) pd_cnt[i]++;
    end
  endtask

  task automatic cyc(input logic r, input logic c, input logic s, input bit glitch = 0);
    Reset = r; countdown = c; doors_sealed = s;
    if (glitch) begin
      #2 Reset = ~r;
      #1 Reset = r;
    end
    @(posedge Clock);
    model_step(r, c, s);
    #1;
    check_all();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin pz_cnt[i] = 0; pd_cnt[i] = 0; end
  endtask

  initial begin
    Reset = 1'b0; countdown = 1'b1; doors_sealed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_fill[i] = -1; m_done[i] = 0; m_fault[i] = 0; m_prev[i] = 1;
    end
    clear_counts();

    // held request through reset release: no start, then one fill per toggle
    repeat (3) cyc(0, 1, 1);
    repeat (5) cyc(1, 1, 1);
    cyc(1, 0, 1);
    clear_counts();
    repeat (24) cyc(1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("held_fill_len[N=%0d]", nval[i]), pz_cnt[i], nval[i]);
      chk($sformatf("held_pulses[N=%0d]", nval[i]), pd_cnt[i], 1);
    end
    repeat (2) cyc(1, 0, 1);

    // nominal single-cycle pulse
    clear_counts();
    cyc(1, 1, 1);
    repeat (18) cyc(1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("nominal_fill_len[N=%0d]", nval[i]), pz_cnt[i], nval[i]);
      chk($sformatf("nominal_pulses[N=%0d]", nval[i]), pd_cnt[i], 1);
    end

    // seal loss at remaining=3 (N=8), fault held while countdown high
    cyc(1, 1, 1);
    repeat (4) cyc(1, 0, 1);
    chk("rem_before_seal_loss", int'(rem0), 3);
    cyc(1, 1, 0);
    chk("fault_after_seal_loss", int'(ft0), 1);
    repeat (3) cyc(1, 1, 1);
    cyc(1, 0, 1);
    chk("fault_cleared", int'(ft0), 0);
    repeat (18) cyc(1, 0, 1);

    // seal loss on the last fill cycle, then start with doors open
    clear_counts();
    cyc(1, 1, 1);
    repeat (7) cyc(1, 0, 1);
    cyc(1, 0, 0);
    chk("last_cycle_seal_loss_fault", int'(ft0), 1);
    cyc(1, 0, 1);
    repeat (10) cyc(1, 0, 1);
    cyc(1, 1, 0);
    chk("open_door_start_fault", int'(ft0), 1);
    cyc(1, 0, 1);

    // reset mid-fill and mid-fault
    cyc(1, 0, 1);
    cyc(1, 1, 1);
    repeat (3) cyc(1, 0, 1);
    cyc(0, 0, 1);
    repeat (3) cyc(1, 0, 1);
    cyc(1, 1, 0);
    cyc(0, 1, 1);
    repeat (3) cyc(1, 0, 1);

    // asynchronous reset glitches between edges
    cyc(1, 1, 1, 1);
    repeat (18) cyc(1, 0, 1, 1);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic r, c, s;
      r = ($urandom_range(0, 199) != 0);
      c = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 39) != 0);
      cyc(r, c, s, ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
